// File: rtl/apb_regfile_slave.sv
// APB completer with a parametrised bank of word-aligned registers, byte strobes,
// configurable wait states, read-only status registers and PSLVERR reporting.
module apb_regfile_slave #(
  parameter int unsigned         ADDR_WIDTH  = 8,
  parameter int unsigned         DATA_WIDTH  = 32,
  parameter int unsigned         NUM_REGS    = 8,
  parameter int unsigned         WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
  localparam int unsigned SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  wr_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0]      setup_idx;
  logic                  in_range;
  logic                  setup_err;
  logic [SEL_W-1:0]      sel;
  logic                  commit;

  always_comb begin
    setup_idx = paddr[ADDR_WIDTH-1:2];
    in_range  = 32'(setup_idx) < NUM_REGS;
    setup_err = (paddr[1:0] != 2'b00) || !in_range ||
                (pwrite && RO_MASK[setup_idx[SEL_W-1:0]]);
  end

  assign sel     = idx_q[SEL_W-1:0];
  assign pready  = (state == ACCESS) && (32'(wait_cnt) == WAIT_STATES);
  assign pslverr = pready && err_q;
  assign commit  = pready && psel && penable;

  // An erroring access never reaches the regs[sel] path, so sel is always in range here.
  always_comb begin
    prdata = '0;
    if (pready && !err_q && !wr_q) begin
      if (RO_MASK[sel]) prdata = status_in[sel*DATA_WIDTH +: DATA_WIDTH];
      else              prdata = regs[sel];
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wr_pulse <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            idx_q    <= setup_idx;
            wr_q     <= pwrite;
            err_q    <= setup_err;
            wait_cnt <= '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (commit) begin
            state <= IDLE;
            if (wr_q && !err_q) begin
              wr_pulse[sel] <= 1'b1;
              for (int unsigned b = 0; b < NUM_LANES; b++) begin
                if (pstrb[b]) regs[sel][b*8 +: 8] <= pwdata[b*8 +: 8];
              end
            end
          end else if (32'(wait_cnt) < WAIT_STATES) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances (0, 2 and 3 wait states) share one
// APB bus; a reference model feeds a scoreboard of expected transfer results.
module tb_apb_regfile_slave;

  logic         clk = 1'b0;
  logic         reset;
  logic         psel, penable, pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [255:0] status_in;
  logic [2:0]   psel_v;
  int           dsel;

  logic [31:0]  prdata_v  [3];
  logic         pready_v  [3];
  logic         pslverr_v [3];
  logic [255:0] regq_v    [3];
  logic [7:0]   wrp_v     [3];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [3][8];

  typedef struct {
    logic [31:0]  rd;
    logic         chk_rd;
    logic         err;
    int           waits;
    logic [7:0]   wrp;
    logic [255:0] regq;
  } exp_t;

  typedef struct {
    logic [31:0]  rd;
    logic         err;
    int           waits;
    logic         to;
    logic [7:0]   wrp;
    logic [255:0] regq;
  } obs_t;

  exp_t sbq  [$];
  obs_t obsq [$];

  always #5 clk = ~clk;

  always_comb begin
    psel_v    = '0;
    psel_v[0] = psel && (dsel == 0);
    psel_v[1] = psel && (dsel == 1);
    psel_v[2] = psel && (dsel == 2);
  end

  apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(0), .RO_MASK(8'h80)) u_ws0 (
    .clk(clk), .reset(reset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0]), .status_in(status_in), .reg_q(regq_v[0]), .wr_pulse(wrp_v[0]));

  apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(2), .RO_MASK(8'h80)) u_ws2 (
    .clk(clk), .reset(reset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1]), .status_in(status_in), .reg_q(regq_v[1]), .wr_pulse(wrp_v[1]));

  apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(3), .RO_MASK(8'h80)) u_ws3 (
    .clk(clk), .reset(reset), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2]), .status_in(status_in), .reg_q(regq_v[2]), .wr_pulse(wrp_v[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic logic [255:0] pack(input int d);
    logic [255:0] r = '0;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = model[d][i];
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Setup phase carries inverted data/strobes so only completion-cycle values can land.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int waits, output logic to);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = ~wd; pstrb = ~st;
    @(posedge clk); #1;
    penable = 1'b1; pwdata = wd; pstrb = st;
    waits = 0; to = 1'b0; rd = '0; err = 1'b0;
    while (1) begin
      @(negedge clk);
      if (pready_v[dsel]) begin
        rd = prdata_v[dsel]; err = pslverr_v[dsel];
        break;
      end
      waits++;
      if (waits > 40) begin to = 1'b1; break; end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic issue(input int d, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    obs_t o;
    int idx;
    logic [31:0] m;
    idx      = int'(addr[7:2]);
    e.err    = (addr[1:0] != 2'b00) || (idx >= 8) || (wr && idx == 7);
    e.waits  = ws_of(d);
    e.chk_rd = !wr;
    e.rd     = '0;
    e.wrp    = '0;
    if (!wr && !e.err) e.rd = (idx == 7) ? status_in[7*32 +: 32] : model[d][idx];
    if (wr && !e.err) begin
      m = model[d][idx];
      for (int b = 0; b < 4; b++) if (st[b]) m[b*8 +: 8] = wd[b*8 +: 8];
      model[d][idx] = m;
      e.wrp[idx] = 1'b1;
    end
    e.regq = pack(d);
    sbq.push_back(e);
    dsel = d;
    xfer(wr, addr, wd, st, o.rd, o.err, o.waits, o.to);
    o.wrp  = wrp_v[d];
    o.regq = regq_v[d];
    obsq.push_back(o);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (prdata_v[d] !== 32'h0) begin n_fail++; $display("FAIL reset_prdata dut%0d got %h want 0", d, prdata_v[d]); end
      n_cmp++; if (pready_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pready dut%0d got %b want 0", d, pready_v[d]); end
      n_cmp++; if (pslverr_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr dut%0d got %b want 0", d, pslverr_v[d]); end
      n_cmp++; if (wrp_v[d] !== 8'h0) begin n_fail++; $display("FAIL reset_wr_pulse dut%0d got %h want 0", d, wrp_v[d]); end
      n_cmp++; if (regq_v[d] !== 256'h0) begin n_fail++; $display("FAIL reset_reg_q dut%0d got %h want 0", d, regq_v[d]); end
    end
  endtask

  task automatic test_rw();
    exp_t e;
    obs_t o;
    issue(0, 1'b1, 8'h00, 32'h0000_0009, 4'hF);
    issue(0, 1'b0, 8'h00, 32'h0, 4'h0);
    issue(0, 1'b1, 8'h08, 32'h1122_3344, 4'hF);
    issue(0, 1'b1, 8'h08, 32'hAABB_CCDD, 4'b0011);
    issue(0, 1'b0, 8'h08, 32'h0, 4'h0);
    issue(0, 1'b1, 8'h10, 32'h5555_AAAA, 4'hF);
    issue(0, 1'b1, 8'h10, 32'hFFFF_FFFF, 4'h0);
    issue(0, 1'b0, 8'h10, 32'h0, 4'h0);
    issue(1, 1'b1, 8'h04, 32'h3139_2E31, 4'hF);
    issue(1, 1'b0, 8'h04, 32'h0, 4'h0);
    issue(2, 1'b1, 8'h14, 32'h1234_5678, 4'b1010);
    issue(2, 1'b1, 8'h0C, 32'hCAFE_F00D, 4'hF);
    issue(2, 1'b0, 8'h14, 32'h0, 4'h0);
    issue(0, 1'b1, 8'h18, 32'h0BAD_C0DE, 4'hF);
    idle(1);
    n_cmp++; if (wrp_v[0] !== 8'h0) begin n_fail++; $display("FAIL pulse_width got %h want 0", wrp_v[0]); end
    for (int k = 0; sbq.size() > 0; k++) begin
      e = sbq.pop_front(); o = obsq.pop_front();
      n_cmp++; if (o.to !== 1'b0) begin n_fail++; $display("FAIL rw_timeout op%0d got %b want 0", k, o.to); end
      n_cmp++; if (o.waits !== e.waits) begin n_fail++; $display("FAIL rw_waits op%0d got %0d want %0d", k, o.waits, e.waits); end
      n_cmp++; if (o.err !== e.err) begin n_fail++; $display("FAIL rw_pslverr op%0d got %b want %b", k, o.err, e.err); end
      if (e.chk_rd) begin
        n_cmp++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL rw_prdata op%0d got %h want %h", k, o.rd, e.rd); end
      end
      n_cmp++; if (o.wrp !== e.wrp) begin n_fail++; $display("FAIL rw_wr_pulse op%0d got %h want %h", k, o.wrp, e.wrp); end
      n_cmp++; if (o.regq !== e.regq) begin n_fail++; $display("FAIL rw_reg_q op%0d got %h want %h", k, o.regq, e.regq); end
    end
  endtask

  task automatic test_errors();
    exp_t e;
    obs_t o;
    issue(0, 1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF);
    issue(0, 1'b1, 8'h06, 32'hFFFF_FFFF, 4'hF);
    issue(0, 1'b1, 8'h1C, 32'hFFFF_FFFF, 4'hF);
    issue(0, 1'b0, 8'h1C, 32'h0, 4'h0);
    issue(0, 1'b0, 8'h40, 32'h0, 4'h0);
    issue(0, 1'b0, 8'h09, 32'h0, 4'h0);
    issue(1, 1'b1, 8'h1C, 32'h1111_1111, 4'hF);
    issue(1, 1'b0, 8'h1C, 32'h0, 4'h0);
    for (int k = 0; sbq.size() > 0; k++) begin
      e = sbq.pop_front(); o = obsq.pop_front();
      n_cmp++; if (o.to !== 1'b0) begin n_fail++; $display("FAIL err_timeout op%0d got %b want 0", k, o.to); end
      n_cmp++; if (o.waits !== e.waits) begin n_fail++; $display("FAIL err_waits op%0d got %0d want %0d", k, o.waits, e.waits); end
      n_cmp++; if (o.err !== e.err) begin n_fail++; $display("FAIL err_pslverr op%0d got %b want %b", k, o.err, e.err); end
      if (e.chk_rd) begin
        n_cmp++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL err_prdata op%0d got %h want %h", k, o.rd, e.rd); end
      end
      n_cmp++; if (o.wrp !== e.wrp) begin n_fail++; $display("FAIL err_wr_pulse op%0d got %h want %h", k, o.wrp, e.wrp); end
      n_cmp++; if (o.regq !== e.regq) begin n_fail++; $display("FAIL err_reg_q op%0d got %h want %h", k, o.regq, e.regq); end
    end
  endtask

  task automatic test_idle_penable();
    dsel = 0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (pready_v[0] !== 1'b0) begin n_fail++; $display("FAIL idle_penable_pready cyc%0d got %b want 0", c, pready_v[0]); end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    n_cmp++; if (regq_v[0] !== pack(0)) begin n_fail++; $display("FAIL idle_penable_reg_q got %h want %h", regq_v[0], pack(0)); end
    n_cmp++; if (wrp_v[0] !== 8'h0) begin n_fail++; $display("FAIL idle_penable_wr_pulse got %h want 0", wrp_v[0]); end
  endtask

  task automatic test_abort();
    exp_t e;
    obs_t o;
    dsel = 2;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge clk);
    n_cmp++; if (pready_v[2] !== 1'b0) begin n_fail++; $display("FAIL abort_pready got %b want 0", pready_v[2]); end
    @(posedge clk); #1;
    penable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_cmp++; if (wrp_v[2] !== 8'h0) begin n_fail++; $display("FAIL abort_wr_pulse cyc%0d got %h want 0", c, wrp_v[2]); end
      n_cmp++; if (regq_v[2] !== pack(2)) begin n_fail++; $display("FAIL abort_reg_q cyc%0d got %h want %h", c, regq_v[2], pack(2)); end
      idle(1);
    end
    issue(2, 1'b1, 8'h10, 32'h600D_D00D, 4'hF);
    issue(2, 1'b0, 8'h14, 32'h0, 4'h0);
    issue(2, 1'b0, 8'h10, 32'h0, 4'h0);
    for (int k = 0; sbq.size() > 0; k++) begin
      e = sbq.pop_front(); o = obsq.pop_front();
      n_cmp++; if (o.waits !== e.waits || o.to !== 1'b0) begin n_fail++; $display("FAIL abort_next_waits op%0d got %0d want %0d", k, o.waits, e.waits); end
      if (e.chk_rd) begin
        n_cmp++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL abort_next_prdata op%0d got %h want %h", k, o.rd, e.rd); end
      end
      n_cmp++; if (o.wrp !== e.wrp) begin n_fail++; $display("FAIL abort_next_wr_pulse op%0d got %h want %h", k, o.wrp, e.wrp); end
      n_cmp++; if (o.regq !== e.regq) begin n_fail++; $display("FAIL abort_next_reg_q op%0d got %h want %h", k, o.regq, e.regq); end
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    obs_t o;
    int waits;
    dsel = 2;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h4D61_6B73; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (waits < 40) begin
      @(negedge clk);
      if (pready_v[2]) break;
      waits++;
    end
    n_cmp++; if (pready_v[2] !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_pready got %b want 1", pready_v[2]); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (pready_v[2] !== 1'b0) begin n_fail++; $display("FAIL rstmid_pready got %b want 0", pready_v[2]); end
    n_cmp++; if (pslverr_v[2] !== 1'b0) begin n_fail++; $display("FAIL rstmid_pslverr got %b want 0", pslverr_v[2]); end
    n_cmp++; if (prdata_v[2] !== 32'h0) begin n_fail++; $display("FAIL rstmid_prdata got %h want 0", prdata_v[2]); end
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (regq_v[d] !== 256'h0) begin n_fail++; $display("FAIL rstmid_reg_q dut%0d got %h want 0", d, regq_v[d]); end
    end
    psel = 1'b0; penable = 1'b0;
    for (int d = 0; d < 3; d++) for (int i = 0; i < 8; i++) model[d][i] = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (wrp_v[2] !== 8'h0) begin n_fail++; $display("FAIL rstmid_wr_pulse got %h want 0", wrp_v[2]); end
    @(posedge clk); #1;
    issue(2, 1'b0, 8'h0C, 32'h0, 4'h0);
    issue(0, 1'b0, 8'h08, 32'h0, 4'h0);
    issue(1, 1'b0, 8'h04, 32'h0, 4'h0);
    for (int k = 0; sbq.size() > 0; k++) begin
      e = sbq.pop_front(); o = obsq.pop_front();
      n_cmp++; if (o.waits !== e.waits || o.to !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_waits op%0d got %0d want %0d", k, o.waits, e.waits); end
      n_cmp++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL rstmid_next_prdata op%0d got %h want %h", k, o.rd, e.rd); end
      n_cmp++; if (o.regq !== e.regq) begin n_fail++; $display("FAIL rstmid_next_reg_q op%0d got %h want %h", k, o.regq, e.regq); end
    end
  endtask

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; dsel = 0;
    status_in = '0;
    for (int i = 0; i < 7; i++) status_in[i*32 +: 32] = 32'h5A00_0000 | i;
    status_in[7*32 +: 32] = 32'hDEAD_BEEF;
    for (int d = 0; d < 3; d++) for (int i = 0; i < 8; i++) model[d][i] = '0;

    test_reset();
    test_rw();
    test_errors();
    test_idle_penable();
    test_abort();
    test_reset_mid_access();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
